// File: rtl/rs_issue_scheduler_if.sv
// Handshake and status bundle between the decoder/stations side (master)
// and the reservation-station issue scheduler (slave).
interface rs_issue_scheduler_if #(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_WIDTH   = 2
);
  logic                   flush;
  logic                   dispatch_valid;
  logic                   dispatch_ready;
  logic                   alloc_we;
  logic [IDX_WIDTH-1:0]   alloc_idx;
  logic [NUM_ENTRIES-1:0] entry_ready;
  logic                   issue_valid;
  logic [IDX_WIDTH-1:0]   issue_idx;
  logic                   issue_ready;
  logic                   clear_en;
  logic [IDX_WIDTH-1:0]   clear_idx;
  logic [IDX_WIDTH:0]     occupancy;
  logic                   empty;
  logic                   full;

  modport master (
    output flush, dispatch_valid, entry_ready, issue_ready,
    input  dispatch_ready, alloc_we, alloc_idx, issue_valid, issue_idx,
           clear_en, clear_idx, occupancy, empty, full
  );

  modport slave (
    input  flush, dispatch_valid, entry_ready, issue_ready,
    output dispatch_ready, alloc_we, alloc_idx, issue_valid, issue_idx,
           clear_en, clear_idx, occupancy, empty, full
  );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Reservation-station allocator and oldest-first issue selector.
// State is a busy bit plus an age rank per entry; all outputs are combinational.
module rs_issue_scheduler #(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  rs_issue_scheduler_if.slave  bus
);

  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic [IDX_WIDTH-1:0]   rank_q [NUM_ENTRIES];
  logic [IDX_WIDTH-1:0]   rank_d [NUM_ENTRIES];

  logic [IDX_WIDTH:0]     occ;
  logic                   full_w;
  logic                   alloc_found;
  logic [IDX_WIDTH-1:0]   alloc_idx_w;
  logic                   sel_found;
  logic [IDX_WIDTH-1:0]   sel_idx;
  logic [IDX_WIDTH-1:0]   sel_rank;
  logic                   dispatch_ready_w;
  logic                   dispatch_fire;
  logic                   issue_valid_w;
  logic                   issue_fire;
  logic [IDX_WIDTH-1:0]   new_rank;

  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      occ = occ + {{IDX_WIDTH{1'b0}}, busy_q[IDX_WIDTH'(i)]};
    end
  end

  assign full_w = (occ == (IDX_WIDTH+1)'(NUM_ENTRIES));

  // Lowest free index, from registered busy bits only: a slot freed by an
  // issue this cycle becomes allocatable on the following cycle.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx_w = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!busy_q[IDX_WIDTH'(i)] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx_w = IDX_WIDTH'(i);
      end
    end
  end

  // Oldest busy and ready entry. Ranks never change without an issue, so the
  // selection stays put under backpressure unless an older entry wakes up.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rank  = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (busy_q[IDX_WIDTH'(i)] && bus.entry_ready[IDX_WIDTH'(i)] &&
          (!sel_found || (rank_q[IDX_WIDTH'(i)] < sel_rank))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_WIDTH'(i);
        sel_rank  = rank_q[IDX_WIDTH'(i)];
      end
    end
  end

  assign dispatch_ready_w = !full_w && !bus.flush && !reset;
  assign dispatch_fire    = bus.dispatch_valid && dispatch_ready_w;
  assign issue_valid_w    = sel_found && !bus.flush && !reset;
  assign issue_fire       = issue_valid_w && bus.issue_ready;
  assign new_rank         = IDX_WIDTH'(occ - {{IDX_WIDTH{1'b0}}, issue_fire});

  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      rank_d[IDX_WIDTH'(i)] = rank_q[IDX_WIDTH'(i)];
    end
    if (reset || bus.flush) begin
      busy_d = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        rank_d[IDX_WIDTH'(i)] = '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (issue_fire && (IDX_WIDTH'(i) == sel_idx)) begin
          busy_d[IDX_WIDTH'(i)] = 1'b0;
          rank_d[IDX_WIDTH'(i)] = '0;
        end else if (issue_fire && busy_q[IDX_WIDTH'(i)] &&
                     (rank_q[IDX_WIDTH'(i)] > sel_rank)) begin
          rank_d[IDX_WIDTH'(i)] = rank_q[IDX_WIDTH'(i)] - 1'b1;
        end
      end
      // The allocated slot is never busy, so it cannot collide with the issuer.
      if (dispatch_fire) begin
        busy_d[alloc_idx_w] = 1'b1;
        rank_d[alloc_idx_w] = new_rank;
      end
    end
  end

  always_ff @(posedge clock) begin
    busy_q <= busy_d;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      rank_q[IDX_WIDTH'(i)] <= rank_d[IDX_WIDTH'(i)];
    end
  end

  assign bus.dispatch_ready = dispatch_ready_w;
  assign bus.alloc_we       = dispatch_fire;
  assign bus.alloc_idx      = alloc_idx_w;
  assign bus.issue_valid    = issue_valid_w;
  assign bus.issue_idx      = issue_valid_w ? sel_idx : '0;
  assign bus.clear_en       = issue_fire;
  assign bus.clear_idx      = issue_valid_w ? sel_idx : '0;
  assign bus.occupancy      = occ;
  assign bus.empty          = (occ == '0);
  assign bus.full           = full_w;

  // Busy ranks must be a permutation of 0..occupancy-1.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (busy_q[IDX_WIDTH'(i)]) begin
          assert ({1'b0, rank_q[IDX_WIDTH'(i)]} < occ)
            else $error("rank out of range at entry %0d", i);
          for (int unsigned j = i + 1; j < NUM_ENTRIES; j++) begin
            if (busy_q[IDX_WIDTH'(j)]) begin
              assert (rank_q[IDX_WIDTH'(i)] != rank_q[IDX_WIDTH'(j)])
                else $error("duplicate rank at entries %0d and %0d", i, j);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboarded bench for rs_issue_scheduler: an age-ordered list model
// predicts each cycle's outputs, a negedge monitor compares them.
module tb_rs_issue_scheduler;
  localparam int N = 4;
  localparam int W = 2;

  logic clock = 1'b0;
  logic reset;

  rs_issue_scheduler_if #(.NUM_ENTRIES(N), .IDX_WIDTH(W)) bus();

  rs_issue_scheduler #(.NUM_ENTRIES(N), .IDX_WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           cyc;
    bit           chk_alloc;
    logic [W-1:0] alloc_idx;
    logic         dispatch_ready;
    logic         alloc_we;
    logic         issue_valid;
    logic [W-1:0] issue_idx;
    logic         clear_en;
    logic [W:0]   occupancy;
    logic         empty;
    logic         full;
  } exp_t;

  exp_t sb[$];
  int   age[$];        // entry indices, oldest first
  bit   mbusy[N];
  int   checks = 0;
  int   passes = 0;
  int   cycle  = 0;

  task automatic chk(input string name, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("dispatch_ready", e.cyc, bus.dispatch_ready, e.dispatch_ready);
      chk("alloc_we",       e.cyc, bus.alloc_we,       e.alloc_we);
      if (e.chk_alloc) chk("alloc_idx", e.cyc, bus.alloc_idx, e.alloc_idx);
      chk("issue_valid",    e.cyc, bus.issue_valid,    e.issue_valid);
      chk("issue_idx",      e.cyc, bus.issue_idx,      e.issue_idx);
      chk("clear_en",       e.cyc, bus.clear_en,       e.clear_en);
      chk("clear_idx",      e.cyc, bus.clear_idx,      e.issue_idx);
      chk("occupancy",      e.cyc, bus.occupancy,      e.occupancy);
      chk("empty",          e.cyc, bus.empty,          e.empty);
      chk("full",           e.cyc, bus.full,           e.full);
    end
  end

  task automatic step(input bit r, input bit f, input bit dv,
                      input logic [N-1:0] er, input bit ir);
    exp_t e;
    int   alloc;
    int   sel;
    #1;
    reset              = r;
    bus.flush          = f;
    bus.dispatch_valid = dv;
    bus.entry_ready    = er;
    bus.issue_ready    = ir;
    #1;
    alloc = -1;
    for (int i = 0; i < N; i++) if (!mbusy[i] && alloc < 0) alloc = i;
    sel = -1;
    foreach (age[k]) if (er[age[k]] && sel < 0) sel = age[k];
    e.cyc            = cycle;
    e.occupancy      = (W+1)'(age.size());
    e.full           = (age.size() == N);
    e.empty          = (age.size() == 0);
    e.chk_alloc      = (alloc >= 0);
    e.alloc_idx      = (alloc >= 0) ? W'(alloc) : '0;
    e.dispatch_ready = !e.full && !f && !r;
    e.alloc_we       = dv && e.dispatch_ready;
    e.issue_valid    = !f && !r && (sel >= 0);
    e.issue_idx      = e.issue_valid ? W'(sel) : '0;
    e.clear_en       = e.issue_valid && ir;
    sb.push_back(e);
    @(posedge clock);
    cycle++;
    if (r || f) begin
      age.delete();
      for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
    end else begin
      if (e.clear_en) begin
        for (int k = 0; k < age.size(); k++) begin
          if (age[k] == sel) begin
            age.delete(k);
            break;
          end
        end
        mbusy[sel] = 1'b0;
      end
      if (e.alloc_we) begin
        age.push_back(alloc);
        mbusy[alloc] = 1'b1;
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.flush          = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.entry_ready    = '0;
    bus.issue_ready    = 1'b0;
    @(posedge clock);

    step(1, 0, 1, 4'b1111, 1);                  // outputs held low in reset
    step(0, 0, 0, 4'b0000, 0);                  // first cycle out of reset

    repeat (4) step(0, 0, 1, 4'b0000, 0);       // fill 0..3
    step(0, 0, 1, 4'b0000, 0);                  // full, no accept
    repeat (3) step(0, 0, 0, 4'b1110, 1);       // issue 1,2,3
    step(0, 0, 0, 4'b0001, 1);                  // issue 0
    step(0, 0, 0, 4'b0000, 0);                  // empty

    repeat (3) step(0, 0, 1, 4'b0000, 0);       // backpressure
    repeat (3) step(0, 0, 0, 4'b0100, 0);
    step(0, 0, 0, 4'b0101, 0);
    step(0, 0, 0, 4'b0101, 1);
    step(0, 0, 0, 4'b0111, 1);
    step(0, 0, 0, 4'b0111, 1);

    step(0, 1, 0, 4'b0000, 0);                  // simultaneous dispatch+issue
    repeat (3) step(0, 0, 1, 4'b0000, 0);
    step(0, 0, 1, 4'b0001, 1);
    repeat (3) step(0, 0, 0, 4'b1110, 1);       // expect 1,2,3

    repeat (4) step(0, 0, 1, 4'b0000, 0);       // full with issue
    step(0, 0, 1, 4'b0100, 1);
    step(0, 0, 1, 4'b0000, 0);
    step(0, 1, 0, 4'b0000, 0);

    repeat (3) step(0, 0, 1, 4'b0000, 0);       // flush with dispatch
    step(0, 1, 1, 4'b0111, 1);
    step(0, 0, 0, 4'b0000, 0);
    repeat (3) step(0, 0, 1, 4'b0000, 0);       // reset mid-operation
    step(1, 0, 1, 4'b0111, 1);
    step(0, 0, 0, 4'b0000, 0);

    repeat (3000) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
           ($urandom % 4) != 0, N'($urandom), ($urandom % 3) != 0);
    end

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clock);
    chk("scoreboard_drained", cycle, sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/rs_issue_scheduler.md
RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

Interface
REQ-001 Parameter NUM_ENTRIES, default 4, number of reservation-station entries managed; SHALL be a power of two >= 2.
REQ-002 Parameter IDX_WIDTH, default 2, entry index width; SHALL equal log2(NUM_ENTRIES).
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all occupied entries (mispredict/exception).
REQ-006 dispatch_valid  input  1  decoder offers one instruction.
REQ-007 dispatch_ready  output  1  a free entry exists; dispatch accepted when dispatch_valid & dispatch_ready.
REQ-008 alloc_we  output  1  write strobe to stations (= dispatch accept).
REQ-009 alloc_idx  output  IDX_WIDTH  entry index to write.
REQ-010 entry_ready  input  NUM_ENTRIES  per-entry rs1_ready & rs2_ready from stations (registered there).
REQ-011 issue_valid  output  1  an occupied, operand-ready entry is selected.
REQ-012 issue_idx  output  IDX_WIDTH  selected entry.
REQ-013 issue_ready  input  1  functional unit accepts; issue fires when issue_valid & issue_ready.
REQ-014 clear_en  output  1  clear strobe to stations (= issue fire).
REQ-015 clear_idx  output  IDX_WIDTH  entry to clear (= issue_idx).
REQ-016 occupancy  output  IDX_WIDTH+1  number of busy entries.
REQ-017 empty, full  output  1 each  occupancy==0, occupancy==NUM_ENTRIES.

Function
REQ-018 State SHALL be per-entry busy bit and per-entry age rank (IDX_WIDTH bits); all outputs combinational from state and current inputs.
REQ-019 Busy entries' ranks SHALL always form a permutation of 0..occupancy-1; rank 0 = oldest.
REQ-020 alloc_idx SHALL be the lowest-index non-busy entry; dispatch_ready = !full & !flush & !reset.
REQ-021 Free-entry decision SHALL use current busy bits only; an entry issuing this cycle is not reusable until the next cycle.
REQ-022 On dispatch accept, at next edge: busy[alloc_idx]=1, rank[alloc_idx] = occupancy - (issue fire ? 1 : 0).
REQ-023 issue_valid = !flush & OR over i of (busy[i] & entry_ready[i]); entry_ready of non-busy entries SHALL be ignored.
REQ-024 issue_idx SHALL be the busy, ready entry with the smallest rank (oldest-first); issue_idx = 0 when issue_valid=0.
REQ-025 issue_idx/issue_valid SHALL be held stable while issue_valid & !issue_ready unless an older entry becomes ready, in which case the older entry SHALL be selected.
REQ-026 On issue fire, at next edge: busy[issue_idx]=0; every busy entry with rank > rank[issue_idx] decrements rank by 1.
REQ-027 Simultaneous dispatch and issue SHALL both take effect in the same edge; occupancy unchanged.
REQ-028 No same-cycle CDB bypass: an entry woken this cycle is eligible only when entry_ready reflects it.
REQ-029 flush SHALL clear all busy bits and ranks at next edge, overriding dispatch and issue; alloc_we and clear_en SHALL be 0 while flush=1.
REQ-030 occupancy SHALL update by +1 (dispatch only), -1 (issue only), 0 (both/neither), never wrapping.

Reset
REQ-031 While reset=1: dispatch_ready=0, alloc_we=0, issue_valid=0, clear_en=0, issue_idx=0, clear_idx=0.
REQ-032 After reset edge: all busy=0, all ranks=0, occupancy=0, empty=1, full=0, alloc_idx=0; dispatch_ready=1 the first cycle reset=0.
REQ-033 Reset SHALL take priority over flush, dispatch and issue; reset mid-operation discards all entries.

Verification
REQ-034 Fill: 4 dispatches, entry_ready=0 -> alloc_idx 0,1,2,3; ranks 0,1,2,3; full=1, dispatch_ready=0 on 5th cycle.
REQ-035 Age order: full, entry_ready=4'b1110, issue_ready=1 -> issues idx1, idx2, idx3 in order; then entry_ready=4'b0001 -> idx0; empty=1.
REQ-036 Backpressure: entry 2 ready, issue_ready=0 for 3 cycles -> issue_idx=2 held, clear_en=0; entry 0 (older) becomes ready -> issue_idx=0.
REQ-037 Simultaneous: occupancy=3 (idx0..2), dispatch + issue idx0 same cycle -> new entry at idx3 rank 2, idx1 rank 0, idx2 rank 1, occupancy=3.
REQ-038 Full with issue: full, issue fires -> dispatch_ready stays 0 that cycle; next cycle alloc_idx = freed index.
REQ-039 Flush/reset: occupancy=3, flush=1 with dispatch_valid=1 -> alloc_we=0, next cycle occupancy=0, empty=1; repeat with reset -> same result plus issue_valid=0 during reset.
